dev_job_ctrl: RTL
=================

Name: dev_job_ctrl

Overview:
- Job front-end for the cube-root/multiply core `dev`; sits directly upstream of it.
- Accepts operand pairs (x, y) over a valid/ready handshake and buffers them in a small FIFO.
- Launches one core computation at a time (start pulse, then waits on the core's rdy), holds y stable for the whole computation, captures the result plus a cycle count, and presents it downstream over valid/ready.

Parameters:
- DEPTH, 4, operand FIFO entries; power of two, ≥2.
- CW, 16, width of the per-job cycle counter.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- in_valid_i  in  1  operand pair offered.
- in_ready_o  out  1  FIFO can accept (= !full).
- x_bi  in  32  radicand.
- y_bi  in  32  multiplier operand.
- core_x_bo  out  32  to core x_bi.
- core_y_bo  out  32  to core y_bi; held stable from issue until done.
- core_start_o  out  1  to core start_i; one-cycle pulse.
- core_rdy_i  in  1  from core rdy_o (1 = idle/done).
- core_res_bi  in  32  from core y_bo.
- out_valid_o  out  1  result available.
- out_ready_i  in  1  downstream accepts.
- res_bo  out  32  captured core result.
- cyc_bo  out  CW  cycles from start pulse to done, saturating.
- level_bo  out  $clog2(DEPTH)+1  FIFO occupancy.
- busy_o  out  1  FSM not in IDLE or FIFO non-empty.

Behaviour:
- Reset values (asynchronous, immediate):
  - in_ready_o=1; all other outputs 0.
  - FIFO pointers and level 0; FSM in IDLE.
  - Reset mid-job discards the FIFO contents and any in-flight result; the core shares rst_i.
- FIFO push: on in_valid_i && in_ready_o.
  - No write when full; in_ready_o=0 exactly when level==DEPTH.
  - Push and pop in the same cycle leave level unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, OUT.
- IDLE -> ISSUE:
  - Condition: FIFO non-empty && core_rdy_i==1.
  - Action: pop the head into core_x_bo/core_y_bo.
- ISSUE -> WAIT_ACK:
  - Action: core_start_o=1 for exactly this one cycle; cycle counter cleared to 1.
- WAIT_ACK: wait for core_rdy_i==0 (the core drops rdy one cycle after sampling start).
  - The counter increments here and in WAIT_DONE, saturating at 2^CW-1.
- WAIT_DONE -> OUT:
  - Condition: core_rdy_i==1.
  - Action: res_bo<=core_res_bi, cyc_bo<=counter, out_valid_o<=1.
- OUT -> IDLE:
  - Hold res_bo/cyc_bo/out_valid_o until out_ready_i==1; the handshake completes in that cycle.
  - out_valid_o drops on the next edge.
  - Minimum one IDLE cycle between jobs.
- core_y_bo must not change from ISSUE until leaving WAIT_DONE; the core samples y only at its final multiply.
- Back-pressure: no new issue while in OUT, so at most one result is outstanding. The FIFO keeps accepting until full.
- Single-entry case (level==1): a push in the same cycle as the pop is permitted.
- core_rdy_i==0 while in IDLE: no issue; wait.
- Result width: res_bo is passed through unchanged (core result fits in 16 LSBs; upper bits 0).

Decomposition:
- Shared package/header: FSM state encodings (IDLE=0 … OUT=4) and default DEPTH/CW constants.
- One natural sub-module: sync_fifo (parameterised width 64 = {y,x}, DEPTH, level output).
- The FSM and counter stay in dev_job_ctrl.

Test Plan:
- Single job, x=27, y=5, out_ready_i=1 -> one start pulse; res_bo=15; out_valid_o one cycle; cyc_bo equals cycles counted by the bench.
- Back-to-back, pushing (1000,2), (8,7), (0,9), (64,3) -> results 20, 14, 0, 12 in order; exactly four start pulses, each issued only with core_rdy_i==1.
- Fill FIFO with 5 pushes while the core is busy and out_ready_i=0 -> in_ready_o=0 at level 4; fifth pair not accepted; level_bo=4; pointers wrap correctly after drain.
- Hold out_ready_i=0 for 20 cycles after a result -> res_bo/cyc_bo stable, no further start pulses; release -> next job issues.
- core_y_bo is monitored throughout a job (x=125, y=4) -> value constant from ISSUE until done; res_bo=20.
- Assert rst_i asynchronously mid WAIT_DONE -> outputs zero immediately, level_bo=0, in_ready_o=1; a subsequent job (27,5) completes with res 15.

Source files
------------

// File: rtl/dev_job_ctrl_pkg.sv
// Shared definitions for the dev core job front-end: FSM encoding, default sizes
// and the operand packing used by the job FIFO.
package dev_job_ctrl_pkg;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_CW    = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_OUT       = 3'd4
  } state_e;

  function automatic logic [63:0] pack_job(input logic [31:0] x, input logic [31:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/dev_job_ctrl_sync_fifo.sv
// Synchronous show-ahead FIFO with occupancy output; pushes are refused when full,
// pops are ignored when empty, pointers wrap modulo DEPTH (power of two).
module dev_job_ctrl_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      level_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o    = (level_r == (AW+1)'(DEPTH));
  assign empty_o   = (level_r == {(AW+1){1'b0}});
  assign level_o   = level_r;
  assign rdata_o   = mem_r[rd_ptr_r];
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;

  // storage write port
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata_i;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + (AW+1)'(1);
        2'b01:   level_r <= level_r - (AW+1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/dev_job_ctrl.sv
// Job front-end for the dev core: buffers operand pairs, launches one core job at a
// time, holds y through the computation and returns result plus cycle count.
module dev_job_ctrl
  import dev_job_ctrl_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW    = DEF_CW
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [31:0]            x_bi,
  input  logic [31:0]            y_bi,
  output logic [31:0]            core_x_bo,
  output logic [31:0]            core_y_bo,
  output logic                   core_start_o,
  input  logic                   core_rdy_i,
  input  logic [31:0]            core_res_bi,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [31:0]            res_bo,
  output logic [CW-1:0]          cyc_bo,
  output logic [$clog2(DEPTH):0] level_bo,
  output logic                   busy_o
);

  state_e        state_r;
  state_e        state_nxt_s;
  logic          pop_s;
  logic [63:0]   fifo_rdata_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [CW-1:0] cnt_r;
  logic [31:0]   core_x_r;
  logic [31:0]   core_y_r;
  logic          start_r;
  logic [31:0]   res_r;
  logic [CW-1:0] cyc_r;
  logic          out_valid_r;

  dev_job_ctrl_sync_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (in_valid_i),
    .wdata_i (pack_job(x_bi, y_bi)),
    .pop_i   (pop_s),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .level_o (level_bo)
  );

  assign in_ready_o   = !fifo_full_s;
  assign busy_o       = (state_r != ST_IDLE) || !fifo_empty_s;
  assign core_x_bo    = core_x_r;
  assign core_y_bo    = core_y_r;
  assign core_start_o = start_r;
  assign res_bo       = res_r;
  assign cyc_bo       = cyc_r;
  assign out_valid_o  = out_valid_r;

  // next-state and pop decision
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s && core_rdy_i) begin
          pop_s       = 1'b1;
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_nxt_s = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (!core_rdy_i) begin
          state_nxt_s = ST_WAIT_DONE;
        end else begin
          state_nxt_s = ST_WAIT_ACK;
        end
      end
      ST_WAIT_DONE: begin
        if (core_rdy_i) begin
          state_nxt_s = ST_OUT;
        end else begin
          state_nxt_s = ST_WAIT_DONE;
        end
      end
      ST_OUT: begin
        if (out_ready_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // operand latch, start pulse, cycle counter and result capture
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      core_x_r    <= 32'd0;
      core_y_r    <= 32'd0;
      start_r     <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      res_r       <= 32'd0;
      cyc_r       <= {CW{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      start_r <= (state_nxt_s == ST_ISSUE);
      // y stays put until the next pop, which cannot happen before OUT completes
      if (pop_s) begin
        {core_y_r, core_x_r} <= fifo_rdata_s;
      end
      if (state_r == ST_ISSUE) begin
        cnt_r <= CW'(1);
      end else if (((state_r == ST_WAIT_ACK) || (state_r == ST_WAIT_DONE)) &&
                   (cnt_r != {CW{1'b1}})) begin
        cnt_r <= cnt_r + CW'(1);
      end
      if ((state_r == ST_WAIT_DONE) && core_rdy_i) begin
        res_r       <= core_res_bi;
        cyc_r       <= cnt_r;
        out_valid_r <= 1'b1;
      end else if ((state_r == ST_OUT) && out_ready_i) begin
        out_valid_r <= 1'b0;
      end
    end
  end

endmodule
